// File: rtl/top_mul_acc_pipe.sv
// Pipelined signed x unsigned multiplier with an optional per-sample accumulate mode,
// accumulator clear, and sticky overflow detection with saturate or wrap behaviour.
module top_mul_acc_pipe #(
   parameter int A_WIDTH   = 14,
   parameter int B_WIDTH   = 5,
   parameter int P_WIDTH   = 14,
   parameter int NUM_STAGE = 4,
   parameter int ACC_WIDTH = 24,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic [A_WIDTH-1:0]   din0,
   input  logic [B_WIDTH-1:0]   din1,
   input  logic                 mode,
   input  logic                 acc_clr,
   output logic                 out_valid,
   output logic [P_WIDTH-1:0]   dout,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 ovf
);

   localparam int FW = A_WIDTH + B_WIDTH + 1;

   logic signed [A_WIDTH-1:0]   r_a;
   logic        [B_WIDTH-1:0]   r_b;
   logic        [NUM_STAGE-1:1] r_vld;
   logic        [NUM_STAGE-1:1] r_mode;
   logic        [NUM_STAGE-1:1] r_clr;

   logic signed [FW-1:0]        w_prod;
   logic signed [FW-1:0]        w_prod_last;
   logic signed [ACC_WIDTH-1:0] w_prod_ext;
   logic        [ACC_WIDTH:0]   w_sum;
   logic                        w_sum_ovf;
   logic        [ACC_WIDTH-1:0] w_acc_next;

   logic                        r_out_valid;
   logic        [P_WIDTH-1:0]   r_dout;
   logic        [ACC_WIDTH-1:0] r_acc;
   logic                        r_ovf;

   // Stage 1 operand capture and control pipe (valid/mode/clr ride alongside the data).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_vld  <= '0;
         r_mode <= '0;
         r_clr  <= '0;
      end else if (ce) begin
         r_a       <= din0;
         r_b       <= din1;
         r_vld[1]  <= in_valid;
         r_mode[1] <= mode;
         r_clr[1]  <= acc_clr;
         for (int k = NUM_STAGE - 1; k >= 2; k--) begin
            r_vld[k]  <= r_vld[k-1];
            r_mode[k] <= r_mode[k-1];
            r_clr[k]  <= r_clr[k-1];
         end
      end
   end

   // Zero-extending din1 by one bit makes it a non-negative signed operand.
   assign w_prod = r_a * $signed({1'b0, r_b});

   generate
      if (NUM_STAGE > 2) begin : g_prod_pipe
         logic signed [FW-1:0] r_prod [2:NUM_STAGE-1];

         // Product carry stages 2..NUM_STAGE-1.
         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int k = 2; k <= NUM_STAGE - 1; k++) begin
                  r_prod[k] <= '0;
               end
            end else if (ce) begin
               r_prod[2] <= w_prod;
               for (int k = 3; k <= NUM_STAGE - 1; k++) begin
                  r_prod[k] <= r_prod[k-1];
               end
            end
         end

         assign w_prod_last = r_prod[NUM_STAGE-1];
      end else begin : g_prod_direct
         assign w_prod_last = w_prod;
      end
   endgenerate

   // Accumulate at ACC_WIDTH+1 bits; differing top two bits mean the signed range was left.
   always_comb begin
      w_prod_ext = ACC_WIDTH'(w_prod_last);
      w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod_ext[ACC_WIDTH-1], w_prod_ext};
      w_sum_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
      if (w_sum_ovf && SATURATE) begin
         if (w_sum[ACC_WIDTH]) begin
            w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         end else begin
            w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else begin
         w_acc_next = w_sum[ACC_WIDTH-1:0];
      end
   end

   // Output stage: truncated product, accumulator load/accumulate and sticky overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
      end else if (ce) begin
         r_out_valid <= r_vld[NUM_STAGE-1];
         if (r_vld[NUM_STAGE-1]) begin
            r_dout <= w_prod_last[P_WIDTH-1:0];
            if (r_mode[NUM_STAGE-1]) begin
               if (r_clr[NUM_STAGE-1]) begin
                  r_acc <= w_prod_ext;
                  r_ovf <= 1'b0;
               end else begin
                  r_acc <= w_acc_next;
                  r_ovf <= r_ovf | w_sum_ovf;
               end
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign dout      = r_dout;
   assign acc_out   = r_acc;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_top_mul_acc_pipe.sv
// Directed bench for top_mul_acc_pipe: a saturating and a wrapping instance share stimulus.
module tb_top_mul_acc_pipe;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic [13:0] din0;
   logic [4:0]  din1;
   logic        mode;
   logic        acc_clr;

   logic        out_valid;
   logic [13:0] dout;
   logic [23:0] acc_out;
   logic        ovf;

   logic        w_out_valid;
   logic [13:0] w_dout;
   logic [23:0] w_acc_out;
   logic        w_ovf;

   int n_checks;
   int n_fail;

   top_mul_acc_pipe #(.SATURATE(1'b1)) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(din0), .din1(din1), .mode(mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .dout(dout), .acc_out(acc_out), .ovf(ovf)
   );

   top_mul_acc_pipe #(.SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(din0), .din1(din1), .mode(mode), .acc_clr(acc_clr),
      .out_valid(w_out_valid), .dout(w_dout), .acc_out(w_acc_out), .ovf(w_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [13:0] a, input logic [4:0] b,
                        input logic m, input logic c);
      in_valid = v;
      din0     = a;
      din1     = b;
      mode     = m;
      acc_clr  = c;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ce    = 1'b1;
      drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
      step();
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (dout !== 14'h0000) begin n_fail++; $display("FAIL reset_dout got %h want 0000", dout); end
      n_checks++; if (acc_out !== 24'h000000) begin n_fail++; $display("FAIL reset_acc got %h want 000000", acc_out); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      n_checks++; if (w_acc_out !== 24'h000000) begin n_fail++; $display("FAIL reset_wrap_acc got %h want 000000", w_acc_out); end
      reset = 1'b1;
   endtask

   // Samples accepted at edges 1..3 appear after edges 4..6.
   task automatic test_multiply();
      logic [13:0] a [3];
      logic [4:0]  b [3];
      logic [13:0] exp_d [3];
      logic        exp_v;
      a[0] = 14'h3FFD; b[0] = 5'd5;  exp_d[0] = 14'h3FF1;
      a[1] = 14'h1FFF; b[1] = 5'd31; exp_d[1] = 14'h1FE1;
      a[2] = 14'h2000; b[2] = 5'd31; exp_d[2] = 14'h2000;
      for (int e = 1; e <= 8; e++) begin
         if (e <= 3) drive(1'b1, a[e-1], b[e-1], 1'b0, 1'b0);
         else        drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
         step();
         exp_v = (e >= 4) && (e <= 6);
         n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL mul_valid edge %0d got %b want %b", e, out_valid, exp_v); end
         if (exp_v) begin
            n_checks++; if (dout !== exp_d[e-4]) begin n_fail++; $display("FAIL mul_dout edge %0d got %h want %h", e, dout, exp_d[e-4]); end
         end
         n_checks++; if (acc_out !== 24'h000000) begin n_fail++; $display("FAIL mul_acc edge %0d got %h want 000000", e, acc_out); end
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] a [3];
      logic [23:0] exp_acc [3];
      logic        exp_v;
      a[0] = 14'd100; exp_acc[0] = 24'd1000;
      a[1] = 14'd200; exp_acc[1] = 24'd3000;
      a[2] = 14'h3FCE; exp_acc[2] = 24'd2500;
      for (int e = 1; e <= 8; e++) begin
         if (e <= 3) drive(1'b1, a[e-1], 5'd10, 1'b1, e == 1);
         else        drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
         step();
         exp_v = (e >= 4) && (e <= 6);
         n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL acc_valid edge %0d got %b want %b", e, out_valid, exp_v); end
         if (exp_v) begin
            n_checks++; if (acc_out !== exp_acc[e-4]) begin n_fail++; $display("FAIL acc_value edge %0d got %0d want %0d", e, acc_out, exp_acc[e-4]); end
         end
         if (e == 4) begin
            n_checks++; if (dout !== 14'd1000) begin n_fail++; $display("FAIL acc_dout got %0d want 1000", dout); end
         end
         n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL acc_ovf edge %0d got %b want 0", e, ovf); end
      end
   endtask

   // 33 * 253921 = 8379393 fits; the 34th sum 8633314 clamps (sat) or wraps to 0x83BBE2.
   task automatic test_saturation_and_wrap();
      int n_out;
      n_out = 0;
      for (int e = 1; e <= 40; e++) begin
         if (e <= 34) drive(1'b1, 14'h1FFF, 5'd31, 1'b1, e == 1);
         else         drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
         step();
         if (out_valid === 1'b1) begin
            n_out++;
            if (n_out == 33) begin
               n_checks++; if (acc_out !== 24'd8379393) begin n_fail++; $display("FAIL sat_acc33 got %0d want 8379393", acc_out); end
               n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf33 got %b want 0", ovf); end
               n_checks++; if (w_acc_out !== 24'd8379393) begin n_fail++; $display("FAIL wrap_acc33 got %0d want 8379393", w_acc_out); end
            end
            if (n_out == 34) begin
               n_checks++; if (acc_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_acc34 got %h want 7fffff", acc_out); end
               n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf34 got %b want 1", ovf); end
               n_checks++; if (w_acc_out !== 24'h83BBE2) begin n_fail++; $display("FAIL wrap_acc34 got %h want 83bbe2", w_acc_out); end
               n_checks++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf34 got %b want 1", w_ovf); end
            end
         end
      end
      n_checks++; if (n_out != 34) begin n_fail++; $display("FAIL sat_count got %0d want 34", n_out); end
      drive(1'b1, 14'd1, 5'd1, 1'b0, 1'b0);
      step();
      drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
      for (int e = 0; e < 5; e++) step();
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
      n_checks++; if (acc_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL mode0_acc_hold got %h want 7fffff", acc_out); end
      n_checks++; if (dout !== 14'd1) begin n_fail++; $display("FAIL mode0_dout got %0d want 1", dout); end
      drive(1'b1, 14'd1, 5'd1, 1'b1, 1'b1);
      step();
      drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
      for (int e = 0; e < 5; e++) step();
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", ovf); end
      n_checks++; if (acc_out !== 24'd1) begin n_fail++; $display("FAIL clr_acc got %0d want 1", acc_out); end
      n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_wrap_ovf got %b want 0", w_ovf); end
   endtask

   // ce low on edges 3..5 pushes outputs from edges 4,5 to 7,8.
   task automatic test_ce_stall();
      int   n_pulse;
      logic exp_v;
      n_pulse = 0;
      for (int e = 1; e <= 10; e++) begin
         ce = !((e >= 3) && (e <= 5));
         if (e == 1)      drive(1'b1, 14'd7, 5'd2, 1'b0, 1'b0);
         else if (e == 2) drive(1'b1, 14'h3FFF, 5'd3, 1'b0, 1'b0);
         else             drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
         step();
         exp_v = (e == 7) || (e == 8);
         if (out_valid === 1'b1) n_pulse++;
         n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stall_valid edge %0d got %b want %b", e, out_valid, exp_v); end
         if (e == 7) begin
            n_checks++; if (dout !== 14'd14) begin n_fail++; $display("FAIL stall_dout1 got %h want 000e", dout); end
         end
         if (e == 8) begin
            n_checks++; if (dout !== 14'h3FFD) begin n_fail++; $display("FAIL stall_dout2 got %h want 3ffd", dout); end
         end
      end
      ce = 1'b1;
      n_checks++; if (n_pulse != 2) begin n_fail++; $display("FAIL stall_pulses got %0d want 2", n_pulse); end
   endtask

   task automatic test_reset_mid();
      logic exp_v;
      for (int e = 1; e <= 10; e++) begin
         reset = (e != 4);
         if (e <= 3)      drive(1'b1, 14'd5, 5'd5, 1'b1, 1'b0);
         else if (e == 5) drive(1'b1, 14'd2, 5'd3, 1'b0, 1'b0);
         else             drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
         step();
         exp_v = (e == 8);
         if (e >= 4) begin
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL rst_valid edge %0d got %b want %b", e, out_valid, exp_v); end
            n_checks++; if (acc_out !== 24'h000000) begin n_fail++; $display("FAIL rst_acc edge %0d got %h want 000000", e, acc_out); end
            n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf edge %0d got %b want 0", e, ovf); end
         end
         if (e == 8) begin
            n_checks++; if (dout !== 14'd6) begin n_fail++; $display("FAIL rst_dout got %0d want 6", dout); end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      ce       = 1'b1;
      drive(1'b0, 14'h0000, 5'h00, 1'b0, 1'b0);
      test_reset();
      test_multiply();
      test_back_to_back();
      test_saturation_and_wrap();
      test_ce_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
